// File: rtl/display_scanner.sv
// Eight-digit multiplexed 7-segment scanner with double-buffered digit capture,
// frame-aligned updates and optional leading-zero blanking.
module display_scanner #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] digits,
    input  logic [7:0]  dp_in,
    input  logic        blank_lz,
    output logic [2:0]  refreshcounter,
    output logic [6:0]  cathode,
    output logic        dp,
    output logic        pending,
    output logic        frame_done
);

    localparam int unsigned DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [31:0]      stage_d;
    logic [7:0]       stage_dp;
    logic [31:0]      act_d;
    logic [7:0]       act_dp;
    logic             blank_q;
    logic             tick;
    logic             boundary;
    logic [7:0]       lead_zero;
    logic [3:0]       cur_code;
    logic [6:0]       seg;

    assign tick     = (div == DIV_MAX);
    assign boundary = tick && (refreshcounter == 3'd7);

    // Slot timing, staging/active buffers and the frame pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div            <= '0;
            refreshcounter <= 3'd0;
            stage_d        <= '0;
            stage_dp       <= '0;
            act_d          <= '0;
            act_dp         <= '0;
            pending        <= 1'b0;
            frame_done     <= 1'b0;
            blank_q        <= 1'b0;
        end else begin
            div        <= tick ? '0 : div + 1'b1;
            frame_done <= boundary;
            blank_q    <= blank_lz;
            if (tick) begin
                refreshcounter <= refreshcounter + 3'd1;
            end
            // Active takes the pre-edge staging, so a coincident load waits a frame.
            if (boundary && pending) begin
                act_d  <= stage_d;
                act_dp <= stage_dp;
            end
            if (load) begin
                stage_d  <= digits;
                stage_dp <= dp_in;
                pending  <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    // A zero is leading while nothing in 1..9 or minus sits above it.
    always_comb begin : lz_scan
        logic       leading;
        logic [3:0] code;
        lead_zero = '0;
        leading   = 1'b1;
        code      = '0;
        for (int i = 7; i >= 1; i--) begin
            code         = act_d[4*i +: 4];
            lead_zero[i] = leading && (code == 4'h0);
            if ((code >= 4'h1) && (code <= 4'hA)) begin
                leading = 1'b0;
            end
        end
    end

    assign cur_code = act_d[{refreshcounter, 2'b00} +: 4];

    always_comb begin
        seg = 7'b1111111;
        case (cur_code)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0111111;
            default: seg = 7'b1111111;
        endcase
    end

    assign cathode = (blank_q && lead_zero[refreshcounter]) ? 7'b1111111 : seg;
    assign dp      = ~act_dp[refreshcounter];

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: per-cycle comparison against a cycle-count model,
// directed frame-boundary sequences and a blanking vector table.
module tb_display_scanner;

    localparam int DIV   = 4;
    localparam int FRAME = DIV * 8;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [31:0] digits;
    logic [7:0]  dp_in;
    logic        blank_lz;
    logic [2:0]  refreshcounter;
    logic [6:0]  cathode;
    logic        dp;
    logic        pending;
    logic        frame_done;

    display_scanner #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .digits(digits), .dp_in(dp_in),
        .blank_lz(blank_lz), .refreshcounter(refreshcounter), .cathode(cathode),
        .dp(dp), .pending(pending), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot and boundary follow directly from cycles since reset.
    int          n;
    logic [31:0] m_sd, m_ad;
    logic [7:0]  m_sdp, m_adp;
    bit          m_pend, m_fd, m_blank, armed;
    logic [6:0]  seg_tab [16];

    initial begin
        armed   = 1'b0;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0111111, 7'b1111111,
                    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
    end

    function automatic int m_slot();
        return (n / DIV) % 8;
    endfunction

    function automatic logic [6:0] exp_cath(input logic [31:0] d, input int s, input bit bl);
        int c;
        int cj;
        bit lead;
        c = int'((d >> (4 * s)) & 32'hF);
        if (bl && s >= 1 && c == 0) begin
            lead = 1'b1;
            for (int j = s + 1; j < 8; j++) begin
                cj = int'((d >> (4 * j)) & 32'hF);
                if (cj >= 1 && cj <= 10) lead = 1'b0;
            end
            if (lead) return 7'b1111111;
        end
        return seg_tab[c];
    endfunction

    always @(posedge clk) begin
        bit bnd;
        if (!rst_n) begin
            n = 0; m_sd = '0; m_sdp = '0; m_ad = '0; m_adp = '0;
            m_pend = 1'b0; m_fd = 1'b0; m_blank = 1'b0; armed = 1'b1;
        end else begin
            bnd = ((n % FRAME) == FRAME - 1);
            if (bnd && m_pend) begin
                m_ad  = m_sd;
                m_adp = m_sdp;
            end
            if (load) begin
                m_sd = digits; m_sdp = dp_in; m_pend = 1'b1;
            end else if (bnd) begin
                m_pend = 1'b0;
            end
            m_fd    = bnd;
            m_blank = blank_lz;
            n++;
        end
    end

    always @(negedge clk) begin
        int s;
        bit e_dp;
        if (armed) begin
            s    = m_slot();
            e_dp = ~m_adp[s];
            chk("refreshcounter", 32'(refreshcounter), 32'(s));
            chk("pending", 32'(pending), 32'(m_pend));
            chk("frame_done", 32'(frame_done), 32'(m_fd));
            chk("cathode", 32'(cathode), 32'(exp_cath(m_ad, s, m_blank)));
            chk("dp", 32'(dp), 32'(e_dp));
        end
    end

    task automatic wait_slot(input int s);
        int k;
        k = 0;
        @(negedge clk);
        while (m_slot() != s && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("wait_slot_timeout", 32'(m_slot()), 32'(s));
    endtask

    task automatic wait_fd();
        int k;
        k = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && k < 80) begin
            @(negedge clk);
            k++;
        end
        chk("wait_frame_done_timeout", 32'(frame_done), 32'd1);
    endtask

    task automatic load_pulse(input logic [31:0] d, input logic [7:0] p);
        load = 1'b1; digits = d; dp_in = p;
        @(negedge clk);
        load = 1'b0;
    endtask

    typedef struct {
        logic [31:0] d;
        bit          bl;
        int          s;
        logic [6:0]  exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int          fdc;
        int          k;
        logic [31:0] cur;
        logic [31:0] mask;

        // Zeros under a minus are significant; B..F above a zero keep it leading.
        tbl.push_back('{32'h0A000050, 1'b1, 7, 7'b1111111});
        tbl.push_back('{32'h0A000050, 1'b1, 6, 7'b0111111});
        tbl.push_back('{32'h0A000050, 1'b1, 5, 7'b1000000});
        tbl.push_back('{32'h0A000050, 1'b1, 2, 7'b1000000});
        tbl.push_back('{32'h0A000050, 1'b1, 1, 7'b0010010});
        tbl.push_back('{32'h0A000050, 1'b1, 0, 7'b1000000});
        tbl.push_back('{32'h0A000050, 1'b0, 7, 7'b1000000});
        tbl.push_back('{32'h00000305, 1'b1, 7, 7'b1111111});
        tbl.push_back('{32'h00000305, 1'b1, 3, 7'b1111111});
        tbl.push_back('{32'h00000305, 1'b1, 2, 7'b0110000});
        tbl.push_back('{32'h00000305, 1'b1, 1, 7'b1000000});
        tbl.push_back('{32'h00000305, 1'b1, 0, 7'b0010010});
        tbl.push_back('{32'h0F0C0000, 1'b1, 5, 7'b1111111});
        tbl.push_back('{32'h0F0C0000, 1'b1, 1, 7'b1111111});
        tbl.push_back('{32'h0F0C0000, 1'b1, 0, 7'b1000000});
        tbl.push_back('{32'h0F0C0000, 1'b0, 1, 7'b1000000});
        tbl.push_back('{32'h0F0C0000, 1'b0, 4, 7'b1111111});
        tbl.push_back('{32'h00000000, 1'b1, 1, 7'b1111111});
        tbl.push_back('{32'h00000000, 1'b1, 0, 7'b1000000});

        checks = 0; failures = 0;
        rst_n = 1'b0; load = 1'b1; digits = 32'hDEADBEEF; dp_in = 8'hFF; blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        load = 1'b0;
        chk("rst_cathode", 32'(cathode), 32'(7'b1000000));
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_refreshcounter", 32'(refreshcounter), 32'd0);
        rst_n = 1'b1;

        fdc = 0;
        repeat (64) begin
            @(negedge clk);
            if (frame_done) fdc++;
        end
        chk("frame_count_64", 32'(fdc), 32'd2);

        wait_slot(3);
        load_pulse(32'h87654321, 8'h04);
        chk("load_pending", 32'(pending), 32'd1);
        chk("load_display_held", 32'(cathode), 32'(7'b1000000));
        wait_fd();
        chk("xfer_pending_clear", 32'(pending), 32'd0);
        chk("xfer_slot0", 32'(cathode), 32'(7'b1111001));
        wait_slot(2);
        chk("xfer_slot2", 32'(cathode), 32'(7'b0110000));
        chk("xfer_slot2_dp", 32'(dp), 32'd0);

        wait_slot(1);
        load_pulse(32'h11111111, 8'h00);
        wait_slot(4);
        load_pulse(32'h22222222, 8'h00);
        wait_fd();
        chk("latest_wins", 32'(cathode), 32'(7'b0100100));

        k = 0;
        @(negedge clk);
        while ((n % FRAME) != FRAME - 1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("boundary_pending_before", 32'(pending), 32'd0);
        load_pulse(32'h99999999, 8'h00);
        chk("boundary_load_pending", 32'(pending), 32'd1);
        chk("boundary_load_fd", 32'(frame_done), 32'd1);
        chk("boundary_load_held", 32'(cathode), 32'(7'b0100100));
        wait_fd();
        chk("boundary_load_shown", 32'(cathode), 32'(7'b0010000));

        cur = 32'h99999999;
        foreach (tbl[i]) begin
            if (tbl[i].d != cur) begin
                load_pulse(tbl[i].d, 8'h00);
                wait_fd();
                cur = tbl[i].d;
            end
            blank_lz = tbl[i].bl;
            wait_slot(tbl[i].s);
            chk($sformatf("blank_vec%0d", i), 32'(cathode), 32'(tbl[i].exp));
        end

        blank_lz = 1'b0;
        wait_slot(5);
        load_pulse(32'h12345678, 8'hAA);
        chk("pre_reset_pending", 32'(pending), 32'd1);
        chk("pre_reset_slot", 32'(refreshcounter), 32'd5);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_pending", 32'(pending), 32'd0);
        chk("midreset_slot", 32'(refreshcounter), 32'd0);
        chk("midreset_cathode", 32'(cathode), 32'(7'b1000000));
        chk("midreset_fd", 32'(frame_done), 32'd0);
        wait_fd();
        chk("midreset_no_xfer", 32'(cathode), 32'(7'b1000000));
        chk("midreset_no_xfer_dp", 32'(dp), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            mask = '0;
            for (int j = 0; j < 8; j++) begin
                if ($urandom_range(1, 0) == 1) mask[4*j +: 4] = 4'hF;
            end
            load   = ($urandom_range(11, 0) == 0);
            digits = $urandom & mask;
            dp_in  = 8'($urandom);
            if ($urandom_range(59, 0) == 0) blank_lz = ~blank_lz;
            rst_n  = ($urandom_range(699, 0) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        load  = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
